// File: rtl/serial_subtractor.sv
// Chunk-serial subtractor: d = a - b - b_in over W bits, K bits per clock,
// with a registered borrow chain and a start/busy/done handshake.
module serial_subtractor #(
  parameter int W = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         b_out,
  output logic         overflow,
  output logic         zero
);

  localparam int N  = W / K;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  acc_q;
  logic          borrow_q;
  logic [IW-1:0] idx_q;

  logic [K-1:0]  aChunk;
  logic [K-1:0]  bChunk;
  logic [K:0]    sliceDiff;
  logic [W-1:0]  acc_d;
  logic          borrow_d;
  logic          lastChunk;

  // One narrow subtract slice; the extra top bit of the difference is the borrow out.
  always_comb begin
    aChunk    = a_q[int'(idx_q) * K +: K];
    bChunk    = b_q[int'(idx_q) * K +: K];
    sliceDiff = {1'b0, aChunk} - {1'b0, bChunk} - {{K{1'b0}}, borrow_q};
    borrow_d  = sliceDiff[K];
    acc_d     = acc_q;
    acc_d[int'(idx_q) * K +: K] = sliceDiff[K-1:0];
    lastChunk = (idx_q == IW'(N - 1));
  end

  assign busy = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      done     <= 1'b0;
      d        <= '0;
      b_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= b_in;
            idx_q    <= '0;
            acc_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          borrow_q <= borrow_d;
          idx_q    <= idx_q + 1'b1;
          // Result registers move only here, so they hold between completions.
          if (lastChunk) begin
            d        <= acc_d;
            b_out    <= borrow_d;
            zero     <= (acc_d == '0);
            overflow <= (a_q[W-1] != b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
            done     <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an arithmetic reference model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_serial_subtractor;

  localparam int W = 16;
  localparam int K = 4;
  localparam int N = W / K;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bIn;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bOut;
  logic         overflow;
  logic         zero;

  int errors = 0;
  int checks = 0;
  bit enableCmp = 1'b0;

  // Reference model state
  int           mCnt = 0;
  logic         mBusy = 1'b0;
  logic         mDone = 1'b0;
  logic [W-1:0] mD = '0;
  logic         mBout = 1'b0;
  logic         mOv = 1'b0;
  logic         mZero = 1'b0;
  logic [W-1:0] pD;
  logic         pBout;
  logic         pOv;

  serial_subtractor #(.W(W), .K(K)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .b_in(bIn),
    .busy(busy), .done(done), .d(d), .b_out(bOut), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Result computed from plain integer arithmetic, independent of chunking.
  task automatic computeResult(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int u;
    int s;
    logic [31:0] uBits;
    u     = int'({16'h0, x}) - int'({16'h0, y}) - int'(bi);
    s     = int'($signed(x)) - int'($signed(y)) - int'(bi);
    uBits = u;
    pD    = uBits[W-1:0];
    pBout = (u < 0);
    pOv   = (s > 32767) || (s < -32768);
  endtask

  // Model: N cycles after an accepted start the results appear with a done pulse.
  always @(posedge clk) begin
    if (reset) begin
      mCnt = 0; mDone = 0; mD = '0; mBout = 0; mOv = 0; mZero = 0;
    end else begin
      mDone = 0;
      if (mCnt > 0) begin
        mCnt--;
        if (mCnt == 0) begin
          mD = pD; mBout = pBout; mOv = pOv; mZero = (pD == '0); mDone = 1;
        end
      end else if (start) begin
        computeResult(a, b, bIn);
        mCnt = N;
      end
    end
    mBusy = (mCnt > 0);
  end

  always @(negedge clk) begin
    if (enableCmp) begin
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("done", 32'(done), 32'(mDone));
      checkOutput("d", 32'(d), 32'(mD));
      checkOutput("b_out", 32'(bOut), 32'(mBout));
      checkOutput("overflow", 32'(overflow), 32'(mOv));
      checkOutput("zero", 32'(zero), 32'(mZero));
    end
  end

  // Entered at posedge+2; leaves at posedge+2 right after the start edge.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    a = x; b = y; bIn = bi; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles, output int busyCycles);
    cycles = 0;
    busyCycles = busy ? 1 : 0;
    while (cycles < 20) begin
      @(posedge clk); #2;
      cycles++;
      if (done) break;
      if (busy) busyCycles++;
    end
    if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic runOp(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic bi, input logic [W-1:0] expD, input logic expBout,
                       input logic expOv, input logic expZero);
    int cycles;
    int busyCycles;
    applyStimulus(x, y, bi);
    waitDone(cycles, busyCycles);
    checkOutput({name, "_latency"}, 32'(cycles), 32'(N));
    checkOutput({name, "_busycycles"}, 32'(busyCycles), 32'(N));
    checkOutput({name, "_d"}, 32'(d), 32'(expD));
    checkOutput({name, "_bout"}, 32'(bOut), 32'(expBout));
    checkOutput({name, "_ov"}, 32'(overflow), 32'(expOv));
    checkOutput({name, "_zero"}, 32'(zero), 32'(expZero));
  endtask

  initial begin
    int cycles;
    int busyCycles;
    bit sawDone;

    // Reset for two cycles with start held high: start must be ignored.
    reset = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h0001; bIn = 1'b0;
    @(posedge clk); #2;
    enableCmp = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0; start = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_d", 32'(d), 32'd0);
    checkOutput("rst_flags", {29'd0, bOut, overflow, zero}, 32'd0);
    @(posedge clk); #2;
    checkOutput("rst_nostart_busy", 32'(busy), 32'd0);

    runOp("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    runOp("ripple", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    runOp("ovneg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    runOp("ovpos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);

    // Reset during cycle 2 of an operation aborts it without a done pulse.
    applyStimulus(16'h4321, 16'h1111, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_d", 32'(d), 32'd0);
    checkOutput("abort_flags", {29'd0, bOut, overflow, zero}, 32'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort_nodone", 32'(sawDone), 32'd0);

    // Zero result, with a start pulse during busy that must be ignored.
    applyStimulus(16'h0005, 16'h0004, 1'b1);
    a = 16'hFFFF; b = 16'h0000; bIn = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    waitDone(cycles, busyCycles);
    checkOutput("zero_latency", 32'(cycles + 1), 32'(N));
    checkOutput("zero_d", 32'(d), 32'h0000);
    checkOutput("zero_flag", 32'(zero), 32'd1);
    checkOutput("zero_bout", 32'(bOut), 32'd0);
    @(posedge clk); #2;
    checkOutput("zero_nosecond", 32'(busy), 32'd0);

    // Back-to-back: new start on the done cycle; first result holds until the second.
    runOp("b2b1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h00FF, 16'h0F00, 1'b0);
    checkOutput("b2b_hold_d", 32'(d), 32'h1000);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    checkOutput("b2b_donedrop", 32'(done), 32'd0);
    waitDone(cycles, busyCycles);
    checkOutput("b2b2_latency", 32'(cycles), 32'(N));
    checkOutput("b2b2_d", 32'(d), 32'hF1FF);
    checkOutput("b2b2_bout", 32'(bOut), 32'd1);
    checkOutput("b2b2_ov", 32'(overflow), 32'd0);

    repeat (3) @(posedge clk);
    #2;
    enableCmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
